consumer: RTL and testbench
===========================

# consumer

Receive-side end of the systolic-array data stream: collects the per-position convolution results emitted by the array, buffers one complete output feature map in raster order, then drains it to downstream logic with a valid/ready handshake. It sits after the array, opposite the input-side stream producer, and provides the frame boundary and backpressure the array output lacks.

## Interface

- WORDWIDTH, 32, width of one result word (two's complement)
- FIG_WIDTH, 28, input feature-map side length
- WEIGHTLEN, 5, kernel side length
- OUT_WIDTH, FIG_WIDTH-WEIGHTLEN+1 (24), output map side length; must be ≥ 2
- OUT_DEPTH, OUT_WIDTH*OUT_WIDTH (576), words per frame
- OUT_ADDRLEN, 10, index width; must satisfy 2^OUT_ADDRLEN ≥ OUT_DEPTH
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  WORDWIDTH  result word from the array
- in_valid  input  1  din valid this cycle
- in_ready  output  1  block accepts din this cycle
- dout  output  WORDWIDTH  buffered result word, raster order
- out_valid  output  1  dout valid
- out_ready  input  1  downstream accepts dout
- frame_done  output  1  one-cycle pulse after last word of a frame drains

## Operation

- Storage: OUT_DEPTH × WORDWIDTH register array; write counter wr_cnt and read counter rd_cnt, each OUT_ADDRLEN bits.
- States: FILL, DRAIN. Reset state FILL.
- FILL: in_ready=1 (except reset cycle). Accept when in_valid&in_ready: buf[wr_cnt]←din, wr_cnt+1. On accept with wr_cnt==OUT_DEPTH-1: wr_cnt←0, state←DRAIN, out_valid←1, dout←buf[0], rd_cnt←1.
- in_valid while in_ready=0 ignored; din is not captured, no error flag.
- DRAIN: in_ready=0. Output regs load on empty-or-handshake: when out_valid&out_ready and rd_cnt<OUT_DEPTH, dout←buf[rd_cnt], rd_cnt+1. Handshake on the last word (word OUT_DEPTH-1): out_valid←0, rd_cnt←0, frame_done←1, state←FILL.
- out_valid=1 with out_ready=0: dout and out_valid hold stable.
- Frames do not overlap: next frame is accepted only after full drain.
- Raster order: word k = row k/OUT_WIDTH, column k%OUT_WIDTH, as received.

## Timing

- Reset (rst=1 at edge): state FILL, wr_cnt=0, rd_cnt=0, in_ready=0, out_valid=0, dout=0, frame_done=0. Buffer contents not cleared. in_ready=1 from the cycle after rst deasserts.
- rst asserted mid-FILL or mid-DRAIN: partial frame discarded, same reset values next cycle.
- Input: one word per cycle max; sustained in_valid fills a frame in OUT_DEPTH cycles.
- Fill→drain latency: dout=word 0 with out_valid=1 in the cycle right after the last accept; in_ready=0 that same cycle.
- Output: one word per cycle with out_ready held high; frame drains in OUT_DEPTH cycles.
- frame_done high exactly the cycle after final output handshake; in_ready=1 in that same cycle.
- All outputs registered; no combinational path in_valid→in_ready or out_ready→out_valid.

## Configuration

- CONSUMER_RELU_EN defined: on write, din with MSB=1 stored as 0; non-negative stored unchanged.
- Not defined: din stored verbatim; negatives pass through.

## Test plan

- Reset: rst=1 two cycles → in_ready=0, out_valid=0, dout=0, frame_done=0; cycle after release in_ready=1.
- Full frame, no stalls: feed din=k for k=0..575 back-to-back, out_ready=1 → dout=0..575 on consecutive cycles starting the cycle after last accept; frame_done one cycle after word 575; in_ready=1 that cycle.
- Backpressure: toggle out_ready 1/0 every cycle during drain → each word held while out_ready=0, no skip/duplicate, 576 words total.
- Input gaps and ignored input: random in_valid gaps in FILL → same output sequence; in_valid=1, din=0xDEADBEEF during DRAIN → not in output, next frame starts at its own word 0.
- ReLU: din=0xFFFFFFFF then 5 → with CONSUMER_RELU_EN dout 0, 5; without, 0xFFFFFFFF, 5.
- Reset mid-drain: rst=1 after 100 words drained → out_valid=0 next cycle, new 576-word frame drains correctly from word 0.

Source files
------------

// File: rtl/consumer.sv
// Output-side frame buffer for the systolic array: fills one full output map, then drains it with valid/ready.
// Optional macro CONSUMER_RELU_EN clamps negative input words to zero as they are stored.
module consumer #(
    parameter int WORDWIDTH   = 32,
    parameter int FIG_WIDTH   = 28,
    parameter int WEIGHTLEN   = 5,
    parameter int OUT_WIDTH   = FIG_WIDTH - WEIGHTLEN + 1,
    parameter int OUT_DEPTH   = OUT_WIDTH * OUT_WIDTH,
    parameter int OUT_ADDRLEN = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORDWIDTH-1:0] dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done
);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [OUT_ADDRLEN-1:0] LAST_IDX = OUT_ADDRLEN'(OUT_DEPTH - 1);
    localparam logic [OUT_ADDRLEN-1:0] ONE      = OUT_ADDRLEN'(1);

    logic [WORDWIDTH-1:0] buf_mem [OUT_DEPTH];

    logic [0:0]             state_q, state_d;
    logic [OUT_ADDRLEN-1:0] wr_cnt_q, wr_cnt_d;
    logic [OUT_ADDRLEN-1:0] rd_cnt_q, rd_cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_done_q, frame_done_d;
    // Set while dout holds the final word of the frame; avoids needing rd_cnt to reach OUT_DEPTH.
    logic                   last_q, last_d;
    logic [WORDWIDTH-1:0]   dout_q;

    logic                   accept;
    logic                   wr_en;
    logic                   load_en;
    logic [OUT_ADDRLEN-1:0] rd_addr;
    logic [WORDWIDTH-1:0]   wr_data;

    assign accept = in_valid & in_ready_q;

`ifdef CONSUMER_RELU_EN
    assign wr_data = din[WORDWIDTH-1] ? '0 : din;
`else
    assign wr_data = din;
`endif

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        last_d       = last_q;
        wr_en        = 1'b0;
        load_en      = 1'b0;
        rd_addr      = rd_cnt_q;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d    = '0;
                        state_d     = ST_DRAIN;
                        out_valid_d = 1'b1;
                        load_en     = 1'b1;
                        rd_addr     = '0;
                        rd_cnt_d    = ONE;
                        last_d      = 1'b0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ONE;
                    end
                end
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    if (last_q) begin
                        out_valid_d  = 1'b0;
                        rd_cnt_d     = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_FILL;
                        last_d       = 1'b0;
                    end else begin
                        load_en  = 1'b1;
                        rd_cnt_d = rd_cnt_q + ONE;
                        last_d   = (rd_cnt_q == LAST_IDX);
                    end
                end
            end
        endcase

        in_ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            last_q       <= last_d;
        end
    end

    // Buffer contents survive reset; only the registered read port is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_cnt_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (load_en) begin
            dout_q <= buf_mem[rd_addr];
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign dout       = dout_q;

endmodule

// File: tb/tb_consumer.sv
// Self-checking bench for consumer: frame-level reference model checked every cycle plus literal spot checks.
module tb_consumer;
    localparam int D = 576;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [31:0] dout;
    logic        out_valid;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    consumer dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: words accepted in a frame, then replayed in order, one per ready cycle.
    logic [31:0] m_frame [D];
    int          m_cnt = 0;
    int          m_rd = 0;
    bit          m_drain = 0, m_valid = 0, m_ready = 0, m_done = 0, started = 0;
    logic [31:0] got_q [$];

    function automatic logic [31:0] m_store(input logic [31:0] v);
`ifdef CONSUMER_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
            if (m_valid) chk("dout", dout, m_frame[m_rd]);
        end
        if (started && !rst && out_valid === 1'b1 && out_ready) got_q.push_back(dout);
        if (rst) begin
            m_cnt = 0; m_rd = 0; m_drain = 0; m_valid = 0; m_ready = 0; m_done = 0;
            started = 1;
        end else if (started) begin
            m_done = 0;
            if (!m_drain) begin
                if (in_valid && m_ready) begin
                    m_frame[m_cnt] = m_store(din);
                    m_cnt++;
                    if (m_cnt == D) begin
                        m_drain = 1; m_valid = 1; m_rd = 0; m_cnt = 0;
                    end
                end
            end else if (out_ready) begin
                m_rd++;
                if (m_rd == D) begin
                    m_drain = 0; m_valid = 0; m_done = 1; m_rd = 0;
                end
            end
            m_ready = !m_drain;
        end
    end

    task automatic feed(input int base, input bit gaps, input bit relu_head);
        bit acc;
        int b;
        for (int k = 0; k < D; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            din = base + k;
            if (relu_head && k == 0) din = 32'hFFFF_FFFF;
            if (relu_head && k == 1) din = 32'd5;
            in_valid = 1'b1;
            b = 0;
            do begin
                acc = in_ready;
                tick();
                b++;
            end while (!acc && b < 100);
            if (!acc) chk("feed_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input bit toggle, input bit junk);
        int  hs = 0;
        int  b = 0;
        bit  ph = 1'b1;
        bit  hs_now;
        got_q.delete();
        in_valid = junk;
        din = 32'hDEAD_BEEF;
        while (hs < n && b < 5000) begin
            out_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            hs_now = out_valid && out_ready;
            tick();
            if (hs_now) hs++;
            b++;
        end
        in_valid = 1'b0;
        if (hs < n) chk("drain_timeout", hs, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Full frame, no stalls
        feed(0, 1'b0, 1'b0);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_dout", dout, 32'd0);
        chk("latency_in_ready", {31'd0, in_ready}, 32'd0);
        drain(D, 1'b0, 1'b0);
        chk("done_pulse", {31'd0, frame_done}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd1);
        chk("f1_count", got_q.size(), D);
        for (int k = 0; k < D; k += 115) chk("f1_word", got_q[k], k);
        chk("f1_last", got_q[D-1], 32'd575);
        tick();
        chk("done_one_cycle", {31'd0, frame_done}, 32'd0);

        // Input gaps, toggling backpressure, junk input during drain
        feed(10000, 1'b1, 1'b0);
        drain(D, 1'b1, 1'b1);
        chk("f2_count", got_q.size(), D);
        chk("f2_first", got_q[0], 32'd10000);
        chk("f2_mid", got_q[300], 32'd10300);
        chk("f2_last", got_q[D-1], 32'd10575);

        // Next frame starts at its own word 0
        feed(20000, 1'b0, 1'b0);
        drain(D, 1'b0, 1'b0);
        chk("f3_first", got_q[0], 32'd20000);
        chk("f3_last", got_q[D-1], 32'd20575);

        // Negative-word handling
        feed(0, 1'b0, 1'b1);
        drain(D, 1'b0, 1'b0);
`ifdef CONSUMER_RELU_EN
        chk("relu_neg", got_q[0], 32'd0);
`else
        chk("relu_neg", got_q[0], 32'hFFFF_FFFF);
`endif
        chk("relu_pos", got_q[1], 32'd5);
        chk("relu_next", got_q[2], 32'd2);

        // Reset in the middle of a drain
        feed(30000, 1'b0, 1'b0);
        drain(100, 1'b0, 1'b0);
        chk("mid_got100", got_q[99], 32'd30099);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_dout", dout, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        feed(40000, 1'b1, 1'b0);
        drain(D, 1'b0, 1'b0);
        chk("f5_count", got_q.size(), D);
        chk("f5_first", got_q[0], 32'd40000);
        chk("f5_last", got_q[D-1], 32'd40575);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
